// File: rtl/hack_io_hub_pkg.sv
// Shared constants for the Hack I/O hub: default addresses, register offsets, STATUS bit positions.
// Latency: n/a (constants and pure functions only).
// Backpressure: n/a.
package hack_io_hub_pkg;

   localparam int DEF_ADDR_KBD     = 'h6000;
   localparam int DEF_ADDR_IO_BASE = 'h6001;

   // STATUS register bit positions
   localparam int STATUS_EMPTY_BIT = 0;
   localparam int STATUS_OVF_BIT   = 1;
   localparam int STATUS_COUNT_LSB = 2;

   // Offsets from the I/O base; the GPIO output words occupy offsets 0..g-1
   function automatic int ofs_gpio_in(input int g);
      return g;
   endfunction

   function automatic int ofs_edge(input int g);
      return g + 1;
   endfunction

   function automatic int ofs_status(input int g);
      return g + 2;
   endfunction

endpackage

// File: rtl/hack_io_fifo.sv
// Synchronous FIFO with push/pop, full/empty flags and an occupancy count.
// Latency: pushed data is visible at dout one clk after the push when the FIFO was empty.
// Backpressure: push on full is dropped unless a pop happens in the same clk; pop on empty is ignored.
module hack_io_fifo #(
   parameter int DEPTH = 8,
   parameter int WIDTH = 8
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     clear,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         din,
   output logic [WIDTH-1:0]         dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      cnt;
   logic             do_push;
   logic             do_pop;

   assign full    = (cnt == FULL_CNT);
   assign empty   = (cnt == '0);
   assign count   = cnt;
   assign dout    = mem[rd_ptr];
   // A full FIFO still accepts a push when a pop frees the slot in the same clk
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);

   // Storage array; clear only resets pointers, stale entries are never read
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (!clear && do_push) begin
         mem[wr_ptr] <= din;
      end
   end

   // Pointers and occupancy count
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else if (clear) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({do_push, do_pop})
            2'b10:   cnt <= cnt + (AW+1)'(1);
            2'b01:   cnt <= cnt - (AW+1)'(1);
            default: cnt <= cnt;
         endcase
      end
   end

endmodule

// File: rtl/hack_io_hub.sv
// Memory-mapped Hack I/O: GPIO output words, synchronised GPIO inputs with sticky edges, keyboard FIFO.
// Latency: reads combinational; writes commit on the clk edge qualified by cpu_strobe.
// Backpressure: kbd_ready = FIFO not full; codes offered while full are dropped and flagged as overflow.
module hack_io_hub
   import hack_io_hub_pkg::*;
#(
   parameter int WORD_WIDTH     = 16,
   parameter int ADDRESS_WIDTH  = 15,
   parameter int GPIO_OUT_WORDS = 2,
   parameter int GPIO_IN_WIDTH  = 8,
   parameter int KBD_FIFO_DEPTH = 8,
   parameter int SYNC_STAGES    = 2,
   parameter int ADDR_KBD       = DEF_ADDR_KBD,
   parameter int ADDR_IO_BASE   = DEF_ADDR_IO_BASE
) (
   input  logic                                 clk,
   input  logic                                 reset_n,
   input  logic                                 hack_reset,
   input  logic                                 cpu_strobe,
   input  logic [ADDRESS_WIDTH-1:0]             addressM,
   input  logic                                 writeM,
   input  logic [WORD_WIDTH-1:0]                outM,
   output logic [WORD_WIDTH-1:0]                inM,
   output logic                                 hit,
   output logic [GPIO_OUT_WORDS*WORD_WIDTH-1:0] gpio_out,
   input  logic [GPIO_IN_WIDTH-1:0]             gpio_in,
   input  logic                                 kbd_valid,
   input  logic [7:0]                           kbd_code,
   output logic                                 kbd_ready,
   output logic                                 kbd_overflow
);

   localparam int G  = GPIO_OUT_WORDS;
   localparam int CW = $clog2(KBD_FIFO_DEPTH) + 1;

   int                      addr_i;
   int                      io_ofs;
   logic                    in_io;
   logic                    sel_kbd;
   logic [G-1:0]            sel_gpio;
   logic                    sel_in;
   logic                    sel_edge;
   logic                    sel_status;
   logic                    wr_en;

   logic [WORD_WIDTH-1:0]    gpio_q [G];
   logic [GPIO_IN_WIDTH-1:0] sync_q [SYNC_STAGES];
   logic [GPIO_IN_WIDTH-1:0] sync_out;
   logic [GPIO_IN_WIDTH-1:0] sync_d;
   logic [GPIO_IN_WIDTH-1:0] edge_q;
   logic [GPIO_IN_WIDTH-1:0] edge_clr;
   logic                     ovf_q;
   logic                     ovf_set;
   logic                     ovf_clr;

   logic                     kbd_pop;
   logic [7:0]               fifo_head;
   logic                     fifo_full;
   logic                     fifo_empty;
   logic [CW-1:0]            fifo_count;

   assign addr_i = int'(addressM);
   assign io_ofs = addr_i - ADDR_IO_BASE;
   assign wr_en  = cpu_strobe && writeM;

   // Address decode for the keyboard register and the contiguous I/O window
   always_comb begin
      sel_gpio   = '0;
      sel_kbd    = (addr_i == ADDR_KBD);
      in_io      = (addr_i >= ADDR_IO_BASE) && (addr_i <= ADDR_IO_BASE + ofs_status(G));
      for (int i = 0; i < G; i++) sel_gpio[i] = in_io && (io_ofs == i);
      sel_in     = in_io && (io_ofs == ofs_gpio_in(G));
      sel_edge   = in_io && (io_ofs == ofs_edge(G));
      sel_status = in_io && (io_ofs == ofs_status(G));
      hit        = sel_kbd || in_io;
   end

   assign kbd_pop  = wr_en && sel_kbd;
   // Full implies non-empty, so a concurrent pop always frees the slot
   assign ovf_set  = kbd_valid && fifo_full && !kbd_pop;
   assign ovf_clr  = wr_en && sel_status && outM[STATUS_OVF_BIT];
   assign edge_clr = (wr_en && sel_edge) ? outM[GPIO_IN_WIDTH-1:0] : '0;
   assign sync_out = sync_q[SYNC_STAGES-1];

   hack_io_fifo #(
      .DEPTH (KBD_FIFO_DEPTH),
      .WIDTH (8)
   ) u_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .clear   (hack_reset),
      .push    (kbd_valid),
      .pop     (kbd_pop),
      .din     (kbd_code),
      .dout    (fifo_head),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .count   (fifo_count)
   );

   // Input synchroniser and edge-detect delay; survives the soft clear
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
         sync_d <= '0;
      end else begin
         sync_q[0] <= gpio_in;
         for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
         sync_d <= sync_out;
      end
   end

   // Software-visible registers; soft clear beats writes, flag sets beat flag clears
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < G; i++) gpio_q[i] <= '0;
         edge_q <= '0;
         ovf_q  <= 1'b0;
      end else if (hack_reset) begin
         for (int i = 0; i < G; i++) gpio_q[i] <= '0;
         edge_q <= '0;
         ovf_q  <= 1'b0;
      end else begin
         for (int i = 0; i < G; i++) if (wr_en && sel_gpio[i]) gpio_q[i] <= outM;
         edge_q <= (edge_q & ~edge_clr) | (sync_out & ~sync_d);
         if (ovf_set)      ovf_q <= 1'b1;
         else if (ovf_clr) ovf_q <= 1'b0;
      end
   end

   // Read mux; unmapped addresses return zero
   always_comb begin
      inM = '0;
      if (sel_kbd && !fifo_empty) inM[7:0] = fifo_head;
      for (int i = 0; i < G; i++) if (sel_gpio[i]) inM = gpio_q[i];
      if (sel_in)   inM[GPIO_IN_WIDTH-1:0] = sync_out;
      if (sel_edge) inM[GPIO_IN_WIDTH-1:0] = edge_q;
      if (sel_status) begin
         inM[STATUS_EMPTY_BIT]           = fifo_empty;
         inM[STATUS_OVF_BIT]             = ovf_q;
         inM[STATUS_COUNT_LSB +: CW]     = fifo_count;
      end
   end

   // Flatten GPIO output words onto the output bus
   always_comb begin
      gpio_out = '0;
      for (int i = 0; i < G; i++) gpio_out[i*WORD_WIDTH +: WORD_WIDTH] = gpio_q[i];
   end

   assign kbd_ready    = !fifo_full;
   assign kbd_overflow = ovf_q;

endmodule

// File: tb/tb_hack_io_hub.sv
// Self-checking bench for hack_io_hub: directed steps plus randomized GPIO/FIFO traffic against a queue model.
// Latency: n/a.
// Backpressure: n/a.
module tb_hack_io_hub;

   localparam logic [14:0] A_KBD    = 15'h6000;
   localparam logic [14:0] A_GPIO0  = 15'h6001;
   localparam logic [14:0] A_GPIO1  = 15'h6002;
   localparam logic [14:0] A_GPIN   = 15'h6003;
   localparam logic [14:0] A_EDGE   = 15'h6004;
   localparam logic [14:0] A_STATUS = 15'h6005;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        hack_reset = 1'b0;
   logic        cpu_strobe = 1'b0;
   logic [14:0] addressM = '0;
   logic        writeM = 1'b0;
   logic [15:0] outM = '0;
   logic [15:0] inM;
   logic        hit;
   logic [31:0] gpio_out;
   logic [7:0]  gpio_in = '0;
   logic        kbd_valid = 1'b0;
   logic [7:0]  kbd_code = '0;
   logic        kbd_ready;
   logic        kbd_overflow;

   int          n_checks = 0;
   int          n_fail = 0;

   // Reference model state
   logic [7:0]  kq[$];
   logic        m_ovf = 1'b0;
   logic [15:0] m_gpio [2];

   hack_io_hub dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .hack_reset   (hack_reset),
      .cpu_strobe   (cpu_strobe),
      .addressM     (addressM),
      .writeM       (writeM),
      .outM         (outM),
      .inM          (inM),
      .hit          (hit),
      .gpio_out     (gpio_out),
      .gpio_in      (gpio_in),
      .kbd_valid    (kbd_valid),
      .kbd_code     (kbd_code),
      .kbd_ready    (kbd_ready),
      .kbd_overflow (kbd_overflow)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic check_rd(input string tag, input logic [14:0] a, input logic [15:0] exp);
      addressM = a;
      #1;
      check(tag, {16'h0, inM}, {16'h0, exp});
   endtask

   // One clk with the given CPU and keyboard activity
   task automatic cyc(input logic v, input logic [7:0] code, input logic wr, input logic stb,
                      input logic [14:0] a, input logic [15:0] d);
      kbd_valid = v; kbd_code = code;
      writeM = wr; cpu_strobe = stb; addressM = a; outM = d;
      tick();
      kbd_valid = 1'b0; writeM = 1'b0; cpu_strobe = 1'b0;
   endtask

   function automatic logic [15:0] exp_status();
      logic [15:0] s = '0;
      s[0]   = (kq.size() == 0);
      s[1]   = m_ovf;
      s[5:2] = 4'(kq.size());
      return s;
   endfunction

   function automatic logic [15:0] exp_kbd();
      logic [15:0] k = '0;
      if (kq.size() > 0) k[7:0] = kq[0];
      return k;
   endfunction

   // Keyboard activity in one clk, mirrored in the queue model
   task automatic kbd_step(input logic v, input logic [7:0] code, input logic pop);
      int  old = kq.size();
      bit  popped = pop && (old > 0);
      cyc(v, code, pop, pop, A_KBD, 16'h0);
      if (popped) void'(kq.pop_front());
      if (v) begin
         if (old < 8 || popped) kq.push_back(code);
         else m_ovf = 1'b1;
      end
   endtask

   initial begin
      logic [7:0]  code;
      logic [15:0] data;
      int          w;
      bit          v, p, stb;

      m_gpio[0] = '0; m_gpio[1] = '0;

      // Reset and idle state
      tick(); tick();
      check("rst_gpio_out", gpio_out, 32'h0);
      check("rst_kbd_ready", {31'h0, kbd_ready}, 32'h1);
      check("rst_kbd_ovf", {31'h0, kbd_overflow}, 32'h0);
      reset_n = 1'b1;
      tick();
      check_rd("idle_status", A_STATUS, 16'h0001);
      check_rd("idle_kbd", A_KBD, 16'h0000);
      check("hit_kbd", {31'h0, hit}, 32'h1);
      addressM = 15'h6006; #1;
      check("miss_hit", {31'h0, hit}, 32'h0);
      check("miss_inM", {16'h0, inM}, 32'h0);
      addressM = 15'h5FFF; #1;
      check("miss_low_hit", {31'h0, hit}, 32'h0);

      // GPIO write gating
      cyc(0, 8'h0, 1, 1, A_GPIO1, 16'hBEEF);
      m_gpio[1] = 16'hBEEF;
      check("gpio_beef", gpio_out, 32'hBEEF_0000);
      cyc(0, 8'h0, 1, 0, A_GPIO1, 16'h1234);
      check("gpio_nostrobe", gpio_out, 32'hBEEF_0000);
      cyc(0, 8'h0, 1, 1, A_GPIN, 16'hFFFF);
      check("gpio_in_wr_ignored", gpio_out, 32'hBEEF_0000);
      check_rd("gpio_in_rd", A_GPIN, 16'h0000);
      check_rd("gpio1_rd", A_GPIO1, 16'hBEEF);

      // Random GPIO writes with random commit strobe
      for (int i = 0; i < 10; i++) begin
         w    = $urandom_range(0, 1);
         data = 16'($urandom);
         stb  = 1'($urandom_range(0, 1));
         cyc(0, 8'h0, 1, stb, A_GPIO0 + 15'(w), data);
         if (stb) m_gpio[w] = data;
         check("gpio_rand", gpio_out, {m_gpio[1], m_gpio[0]});
         check_rd("gpio_rand_rd", A_GPIO0 + 15'(w), m_gpio[w]);
      end

      // FIFO order
      kbd_step(1, 8'h61, 0);
      kbd_step(1, 8'h62, 0);
      kbd_step(1, 8'h63, 0);
      check_rd("fifo_head_61", A_KBD, 16'h0061);
      check_rd("fifo_cnt3", A_STATUS, 16'h000C);
      kbd_step(0, 8'h0, 1);
      kbd_step(0, 8'h0, 1);
      check_rd("fifo_head_63", A_KBD, 16'h0063);

      // Random push/pop traffic, including overflow and pointer wrap
      for (int i = 0; i < 60; i++) begin
         v    = ($urandom_range(0, 9) < 6);
         p    = ($urandom_range(0, 9) < 4);
         code = 8'($urandom);
         kbd_step(v, code, p);
         check_rd("fifo_rand_status", A_STATUS, exp_status());
         check_rd("fifo_rand_kbd", A_KBD, exp_kbd());
         check("fifo_rand_ready", {31'h0, kbd_ready}, {31'h0, kq.size() < 8});
      end
      cyc(0, 8'h0, 1, 1, A_STATUS, 16'h0002);
      m_ovf = 1'b0;
      for (int i = 0; i < 9; i++) begin
         if (kq.size() > 0) begin
            check_rd("drain_kbd", A_KBD, exp_kbd());
            kbd_step(0, 8'h0, 1);
         end
      end
      check_rd("drained_status", A_STATUS, 16'h0001);
      kbd_step(0, 8'h0, 1);
      check_rd("pop_empty_status", A_STATUS, 16'h0001);

      // Full and overflow
      for (int i = 0; i < 8; i++) kbd_step(1, 8'hA0 + 8'(i), 0);
      check("full_ready", {31'h0, kbd_ready}, 32'h0);
      check_rd("full_status", A_STATUS, 16'h0020);
      kbd_step(1, 8'hEE, 0);
      check_rd("ovf_status", A_STATUS, 16'h0022);
      check("ovf_mirror", {31'h0, kbd_overflow}, 32'h1);
      check_rd("ovf_head", A_KBD, 16'h00A0);
      cyc(0, 8'h0, 1, 1, A_STATUS, 16'h0002);
      check_rd("ovf_clear", A_STATUS, 16'h0020);
      cyc(0, 8'h0, 1, 1, A_STATUS, 16'hFFFD);
      check_rd("status_ro_bits", A_STATUS, 16'h0020);
      cyc(1, 8'hEF, 1, 1, A_STATUS, 16'h0002);
      check_rd("ovf_set_wins", A_STATUS, 16'h0022);
      cyc(0, 8'h0, 1, 1, A_STATUS, 16'h0002);
      m_ovf = 1'b0;
      kbd_step(1, 8'hB0, 1);
      check_rd("full_pushpop_status", A_STATUS, 16'h0020);
      check_rd("full_pushpop_head", A_KBD, 16'h00A1);
      check_rd("full_pushpop_model", A_STATUS, exp_status());

      // Edge flags
      gpio_in = 8'h08;
      tick(); tick();
      check_rd("sync_gpin", A_GPIN, 16'h0008);
      check_rd("edge_not_yet", A_EDGE, 16'h0000);
      tick();
      check_rd("edge_bit3", A_EDGE, 16'h0008);
      gpio_in = 8'h28;
      tick(); tick();
      cyc(0, 8'h0, 1, 1, A_EDGE, 16'h0008);
      check_rd("edge_clr_and_set", A_EDGE, 16'h0020);
      tick();
      check_rd("edge_sticky", A_EDGE, 16'h0020);

      // Soft reset mid-operation
      for (int i = 0; i < 4; i++) kbd_step(0, 8'h0, 1);
      cyc(0, 8'h0, 1, 1, A_GPIO0, 16'h1234);
      m_gpio[0] = 16'h1234;
      check("pre_soft_gpio", gpio_out, {m_gpio[1], m_gpio[0]});
      check_rd("pre_soft_status", A_STATUS, 16'h0010);
      hack_reset = 1'b1;
      cyc(1, 8'h77, 1, 1, A_GPIO0, 16'h5555);
      hack_reset = 1'b0;
      kq.delete();
      m_ovf = 1'b0;
      check("soft_gpio", gpio_out, 32'h0);
      check_rd("soft_status", A_STATUS, 16'h0001);
      check_rd("soft_kbd", A_KBD, 16'h0000);
      check_rd("soft_edge", A_EDGE, 16'h0000);
      check_rd("soft_sync_kept", A_GPIN, 16'h0028);
      tick();
      check_rd("soft_no_false_edge", A_EDGE, 16'h0000);

      // Asynchronous reset clears the synchroniser too
      reset_n = 1'b0;
      #1;
      check_rd("arst_gpin", A_GPIN, 16'h0000);
      check("arst_ready", {31'h0, kbd_ready}, 32'h1);
      tick();
      reset_n = 1'b1;
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
